// File: rtl/raster_window_ctrl.sv
// Raster scan controller: tags each accepted pixel with col/row, 3x3-window, end-of-line and end-of-frame flags.
// Latency: 1 cycle from pixel acceptance to out_valid; frame_done pulses 1 cycle after the last tag drains.
// Backpressure: a single output register; in_ready drops while it is full and out_ready is low.
module raster_window_ctrl #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [COL_BITS-1:0] img_width,
    input  logic [ROW_BITS-1:0] img_height,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COL_BITS-1:0] out_col,
    output logic [ROW_BITS-1:0] out_row,
    output logic                window_valid,
    output logic                eol,
    output logic                eof,
    output logic                frame_done,
    output logic                cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [COL_BITS-1:0] w_q;
    logic [ROW_BITS-1:0] h_q;
    logic [COL_BITS-1:0] col_q;
    logic [ROW_BITS-1:0] row_q;
    logic                out_valid_q;
    logic [COL_BITS-1:0] out_col_q;
    logic [ROW_BITS-1:0] out_row_q;
    logic                window_valid_q;
    logic                eol_q;
    logic                eof_q;
    logic                frame_done_q;
    logic                cfg_err_q;

    logic                in_ready_d;
    logic                accept_d;
    logic                last_col_d;
    logic                last_row_d;
    logic                dims_ok_d;
    logic [COL_BITS-1:0] col_d;
    logic [ROW_BITS-1:0] row_d;

    // Handshake, position decode and next raster position for the pixel being accepted
    always_comb begin
        in_ready_d = (state_q == SCAN) && (!out_valid_q || out_ready);
        accept_d   = in_valid && in_ready_d;
        last_col_d = (col_q == (w_q - COL_BITS'(1)));
        last_row_d = (row_q == (h_q - ROW_BITS'(1)));
        dims_ok_d  = (img_width >= COL_BITS'(3)) && (img_height >= ROW_BITS'(3));
        col_d      = col_q;
        row_d      = row_q;
        if (last_col_d) begin
            col_d = '0;
            // The eof pixel rewinds the raster to the origin for the next frame
            row_d = last_row_d ? '0 : (row_q + ROW_BITS'(1));
        end else begin
            col_d = col_q + COL_BITS'(1);
        end
    end

    // Frame FSM, raster counters and the registered output tag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            w_q            <= '0;
            h_q            <= '0;
            col_q          <= '0;
            row_q          <= '0;
            out_valid_q    <= 1'b0;
            out_col_q      <= '0;
            out_row_q      <= '0;
            window_valid_q <= 1'b0;
            eol_q          <= 1'b0;
            eof_q          <= 1'b0;
            frame_done_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            cfg_err_q    <= 1'b0;
            frame_done_q <= 1'b0;

            // A new tag overwrites the register even while the old one is being consumed
            if (accept_d) begin
                out_valid_q    <= 1'b1;
                out_col_q      <= col_q;
                out_row_q      <= row_q;
                window_valid_q <= (col_q >= COL_BITS'(2)) && (row_q >= ROW_BITS'(2));
                eol_q          <= last_col_d;
                eof_q          <= last_col_d && last_row_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (dims_ok_d) begin
                            w_q     <= img_width;
                            h_q     <= img_height;
                            col_q   <= '0;
                            row_q   <= '0;
                            state_q <= SCAN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (accept_d) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        if (last_col_d && last_row_d) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_q || out_ready) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_d;
    assign out_valid    = out_valid_q;
    assign out_col      = out_col_q;
    assign out_row      = out_row_q;
    assign window_valid = window_valid_q;
    assign eol          = eol_q;
    assign eof          = eof_q;
    assign frame_done   = frame_done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_raster_window_ctrl.sv
// Bench for raster_window_ctrl: directed scenarios plus randomized handshakes.
// Expected tags come from a raster-order queue of (col,row) pixels built per frame.
// Handshake behaviour is predicted from a queue/occupancy model of the output register.
module tb_raster_window_ctrl;

    localparam int CB = 10;
    localparam int RB = 10;

    typedef logic [CB+RB+2:0] tag_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CB-1:0] img_width;
    logic [RB-1:0] img_height;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [CB-1:0] out_col;
    logic [RB-1:0] out_row;
    logic          window_valid;
    logic          eol;
    logic          eof;
    logic          frame_done;
    logic          cfg_err;

    int vectors     = 0;
    int miscompares = 0;

    tag_t obs;
    tag_t exp_q[$];
    tag_t exp_t;

    always #5 clk = ~clk;

    assign obs = {out_col, out_row, window_valid, eol, eof};

    raster_window_ctrl #(.COL_BITS(CB), .ROW_BITS(RB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_row(out_row),
        .window_valid(window_valid), .eol(eol), .eof(eof),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    // Expected tag of pixel (c,r) in a WxH frame
    function automatic tag_t tag_of(int c, int r, int w, int h);
        logic [CB-1:0] cc;
        logic [RB-1:0] rr;
        cc = CB'(c);
        rr = RB'(r);
        return {cc, rr, (c >= 2 && r >= 2), (c == w - 1), (c == w - 1 && r == h - 1)};
    endfunction

    // All pixels of a frame in raster order
    task automatic build(input int w, input int h);
        exp_q.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_q.push_back(tag_of(c, r, w, h));
    endtask

    // One clock cycle: drive just after the rising edge, return at the falling edge for sampling
    task automatic cyc(input logic r, input logic st, input logic iv, input logic ordy);
        @(posedge clk);
        #1;
        rst = r; start = st; in_valid = iv; out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic set_dims(input int w, input int h);
        img_width  = CB'(w);
        img_height = RB'(h);
    endtask

    task automatic test_reset;
        set_dims(4, 4);
        cyc(1, 1, 1, 1);
        cyc(1, 1, 1, 1);
        vectors++;
        if ({out_valid, in_ready, frame_done, cfg_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {out_valid, in_ready, frame_done, cfg_err});
        end
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_tag: got %h want 0", obs);
        end
        cyc(0, 0, 1, 1);
        vectors++;
        if (in_ready !== 1'b0 || cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: in_ready=%b cfg_err=%b want 0 0", in_ready, cfg_err);
        end
    endtask

    task automatic test_full_frame;
        int acc_n = 0, acc_cyc = -1, fd_cyc = -1, outs = 0;
        set_dims(4, 3);
        build(4, 3);
        cyc(0, 1, 1, 1);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_idle_rdy: got %b want 0", in_ready);
        end
        for (int k = 1; k <= 40 && fd_cyc < 0; k++) begin
            cyc(0, 0, 1, 1);
            if (in_valid && in_ready) begin
                acc_n++;
                if (acc_n == 12) acc_cyc = k;
            end
            if (out_valid && out_ready) begin
                outs++;
                vectors++;
                exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (obs !== exp_t) begin
                    miscompares++;
                    $display("FAIL full_tag: got %h want %h", obs, exp_t);
                end
            end
            if (frame_done) fd_cyc = k;
        end
        vectors++;
        if (outs != 12 || fd_cyc < 0) begin
            miscompares++;
            $display("FAIL full_count: outputs=%0d done_cycle=%0d want 12 and a done pulse", outs, fd_cyc);
        end
        vectors++;
        if (fd_cyc - acc_cyc != 2) begin
            miscompares++;
            $display("FAIL full_done_lat: got %0d want 2", fd_cyc - acc_cyc);
        end
        cyc(0, 0, 1, 1);
        vectors++;
        if (frame_done !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_after_done: frame_done=%b in_ready=%b want 0 0", frame_done, in_ready);
        end
    endtask

    task automatic test_backpressure;
        int outs = 0;
        bit fd = 0;
        logic ordy;
        set_dims(4, 3);
        build(4, 3);
        cyc(0, 1, 1, 1);
        for (int k = 1; k <= 50 && !fd; k++) begin
            ordy = !(k >= 7 && k < 12);
            cyc(0, 0, 1, ordy);
            if (!ordy) begin
                vectors++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL bp_hold: in_ready=%b out_valid=%b tag=%h want 0 1 %h",
                             in_ready, out_valid, obs, exp_q[0]);
                end
            end
            if (out_valid && out_ready) begin
                outs++;
                vectors++;
                exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (obs !== exp_t) begin
                    miscompares++;
                    $display("FAIL bp_tag: got %h want %h", obs, exp_t);
                end
            end
            if (frame_done) fd = 1;
        end
        vectors++;
        if (outs != 12 || !fd) begin
            miscompares++;
            $display("FAIL bp_count: outputs=%0d done=%0d want 12 1", outs, fd);
        end
    endtask

    task automatic test_cfg_err;
        int ws[4] = '{2, 5, 0, 3};
        int hs[4] = '{5, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            set_dims(ws[i], hs[i]);
            cyc(0, 1, 1, 1);
            vectors++;
            if (cfg_err !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_early: got %b want 0 (dims %0dx%0d)", cfg_err, ws[i], hs[i]);
            end
            cyc(0, 0, 1, 1);
            vectors++;
            if (cfg_err !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_pulse: cfg_err=%b in_ready=%b want 1 0 (dims %0dx%0d)",
                         cfg_err, in_ready, ws[i], hs[i]);
            end
            cyc(0, 0, 1, 1);
            vectors++;
            if (cfg_err !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_after: cfg_err=%b in_ready=%b out_valid=%b want 0 0 0",
                         cfg_err, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_start_ignored;
        int outs = 0;
        bit fd = 0;
        set_dims(5, 5);
        build(5, 5);
        cyc(0, 1, 1, 1);
        for (int k = 1; k <= 60 && !fd; k++) begin
            if (k == 7) set_dims(3, 3);
            if (k == 8) set_dims(1, 1);
            cyc(0, (k == 7 || k == 8), 1, 1);
            vectors++;
            if (cfg_err !== 1'b0) begin
                miscompares++;
                $display("FAIL ign_cfg: got %b want 0 at cycle %0d", cfg_err, k);
            end
            if (out_valid && out_ready) begin
                outs++;
                vectors++;
                exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (obs !== exp_t) begin
                    miscompares++;
                    $display("FAIL ign_tag: got %h want %h", obs, exp_t);
                end
            end
            if (frame_done) fd = 1;
        end
        vectors++;
        if (outs != 25 || !fd) begin
            miscompares++;
            $display("FAIL ign_count: outputs=%0d done=%0d want 25 1", outs, fd);
        end
    endtask

    task automatic test_reset_midframe;
        int acc = 0, outs = 0, fds = 0;
        bit fd = 0;
        set_dims(4, 4);
        build(4, 4);
        cyc(0, 1, 1, 1);
        for (int k = 1; k <= 20 && acc < 5; k++) begin
            cyc(0, 0, 1, 1);
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                vectors++;
                exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (obs !== exp_t) begin
                    miscompares++;
                    $display("FAIL rstmid_pre_tag: got %h want %h", obs, exp_t);
                end
            end
        end
        // Reset lands in the cycle that would accept pixel (1,1)
        cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 1);
            if (frame_done) fds++;
        end
        vectors++;
        if (fds != 0) begin
            miscompares++;
            $display("FAIL rstmid_no_done: got %0d done pulses want 0", fds);
        end
        build(4, 4);
        cyc(0, 1, 1, 1);
        for (int k = 1; k <= 40 && !fd; k++) begin
            cyc(0, 0, 1, 1);
            if (out_valid && out_ready) begin
                outs++;
                vectors++;
                exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (obs !== exp_t) begin
                    miscompares++;
                    $display("FAIL rstmid_tag: got %h want %h", obs, exp_t);
                end
            end
            if (frame_done) fd = 1;
        end
        vectors++;
        if (outs != 16 || !fd) begin
            miscompares++;
            $display("FAIL rstmid_count: outputs=%0d done=%0d want 16 1", outs, fd);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1, last = -1, nvld = 0, nwin = 0;
        bit fd = 0;
        set_dims(3, 3);
        build(3, 3);
        cyc(0, 1, 1, 1);
        for (int k = 1; k <= 30 && !fd; k++) begin
            cyc(0, 0, 1, 1);
            if (out_valid) begin
                nvld++;
                if (first < 0) first = k;
                last = k;
                if (window_valid) nwin++;
            end
            if (out_valid && out_ready) begin
                vectors++;
                exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (obs !== exp_t) begin
                    miscompares++;
                    $display("FAIL b2b_tag: got %h want %h", obs, exp_t);
                end
            end
            if (frame_done) fd = 1;
        end
        vectors++;
        if (nvld != 9 || last - first + 1 != 9) begin
            miscompares++;
            $display("FAIL b2b_run: valid_cycles=%0d span=%0d want 9 9", nvld, last - first + 1);
        end
        vectors++;
        if (nwin != 1 || !fd) begin
            miscompares++;
            $display("FAIL b2b_window: windows=%0d done=%0d want 1 1", nwin, fd);
        end
    endtask

    task automatic test_random;
        int w, h, budget;
        logic iv, ordy, exp_ir, acc, cons, nxt_fd;
        logic m_hold, m_drain, m_fd;
        tag_t m_reg;
        bit done;
        for (int f = 0; f < 7; f++) begin
            if (f == 6) begin
                w = (1 << CB) - 1;
                h = 3;
            end else begin
                w = $urandom_range(3, 8);
                h = $urandom_range(3, 6);
            end
            set_dims(w, h);
            cyc(0, 1, 0, 0);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_start_rdy: got %b want 0", in_ready);
            end
            build(w, h);
            m_hold = 0; m_drain = 0; m_fd = 0; m_reg = '0; done = 0;
            budget = 20 * w * h + 50;
            for (int k = 0; k < budget && !done; k++) begin
                iv   = ($urandom_range(0, 9) < 7);
                ordy = ($urandom_range(0, 9) < 7);
                cyc(0, 0, iv, ordy);
                exp_ir = (exp_q.size() > 0) && (!m_hold || ordy);
                vectors++;
                if (in_ready !== exp_ir || out_valid !== m_hold || frame_done !== m_fd) begin
                    miscompares++;
                    $display("FAIL rnd_ctrl: rdy/vld/done=%b%b%b want %b%b%b (frame %0dx%0d)",
                             in_ready, out_valid, frame_done, exp_ir, m_hold, m_fd, w, h);
                end
                if (m_hold) begin
                    vectors++;
                    if (obs !== m_reg) begin
                        miscompares++;
                        $display("FAIL rnd_tag: got %h want %h", obs, m_reg);
                    end
                end
                if (m_fd) done = 1;
                acc    = iv && exp_ir;
                cons   = m_hold && ordy;
                nxt_fd = m_drain && (!m_hold || ordy);
                if (nxt_fd) m_drain = 0;
                if (acc) begin
                    m_reg  = exp_q.pop_front();
                    m_hold = 1;
                    if (exp_q.size() == 0) m_drain = 1;
                end else if (cons) begin
                    m_hold = 0;
                end
                m_fd = nxt_fd;
            end
            vectors++;
            if (!done) begin
                miscompares++;
                $display("FAIL rnd_timeout: frame %0dx%0d did not finish, %0d pixels left", w, h, exp_q.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        img_width = '0; img_height = '0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_cfg_err();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/raster_window_ctrl.md
RASTER_WINDOW_CTRL -- requirements
Module: raster_window_ctrl

Interface
REQ-001 The block SHALL have parameter COL_BITS, default 10: width of the column counter and of img_width.
REQ-002 The block SHALL have parameter ROW_BITS, default 10: width of the row counter and of img_height.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle frame start request.
REQ-006 The block SHALL have port img_width, input, COL_BITS bits: pixels per line, sampled on an accepted start.
REQ-007 The block SHALL have port img_height, input, ROW_BITS bits: lines per frame, sampled on an accepted start.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the upstream pixel strobe is present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the output tag register holds data.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the output this cycle.
REQ-012 The block SHALL have port out_col, output, COL_BITS bits: column of the tagged pixel.
REQ-013 The block SHALL have port out_row, output, ROW_BITS bits: row of the tagged pixel.
REQ-014 The block SHALL have port window_valid, output, 1 bit: a full 3x3 window ends at this pixel.
REQ-015 The block SHALL have port eol, output, 1 bit: the tagged pixel is the last pixel of its line.
REQ-016 The block SHALL have port eof, output, 1 bit: the tagged pixel is the last pixel of the frame.
REQ-017 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the frame is fully drained.
REQ-018 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-019 The FSM SHALL use states IDLE, SCAN, DRAIN and DONE.
REQ-020 In IDLE, a start with img_width>=3 and img_height>=3 SHALL latch both dimensions, clear col/row to 0 and move the FSM to SCAN.
REQ-021 In IDLE, a start with either dimension <3 SHALL pulse cfg_err in the next cycle and leave the FSM in IDLE.
REQ-022 A start in SCAN, DRAIN or DONE SHALL be ignored, with no cfg_err and no effect on the latched dimensions.
REQ-023 in_ready SHALL equal (state==SCAN) && (!out_valid || out_ready).
REQ-024 A pixel SHALL be accepted only when in_valid && in_ready; in_valid alone SHALL change nothing.
REQ-025 On acceptance, the output register SHALL load in the same edge: out_col=col, out_row=row, window_valid=(col>=2 && row>=2), eol=(col==W-1), eof=(col==W-1 && row==H-1); out_valid SHALL assert, giving 1-cycle latency.
REQ-026 out_valid and all tag outputs SHALL hold stable while out_valid && !out_ready.
REQ-027 out_valid SHALL clear when out_ready is high and no new pixel is accepted in the same cycle; a simultaneous consume and accept SHALL overwrite the register with no bubble.
REQ-028 On acceptance with col<W-1, col SHALL increment.
REQ-029 On acceptance with col==W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-030 Acceptance of the eof pixel SHALL move the FSM to DRAIN and clear col/row to 0.
REQ-031 DRAIN SHALL move the FSM to DONE once out_valid is 0, or when out_valid && out_ready.
REQ-032 frame_done SHALL be high for exactly the one cycle the FSM spends in DONE, after which the FSM returns to IDLE.
REQ-033 Counter arithmetic SHALL be unsigned, with comparisons done at full parameter width; W=2^COL_BITS-1 SHALL be legal.

Reset
REQ-034 rst high at a clock edge SHALL force state=IDLE, col=0, row=0, out_valid=0, out_col=0, out_row=0, window_valid=0, eol=0, eof=0, frame_done=0, cfg_err=0, in_ready=0, latched dimensions=0.
REQ-035 rst SHALL take priority over start, acceptance and consumption, including mid-frame; no frame_done SHALL follow a reset.

Verification
REQ-036 W=4, H=3, in_valid and out_ready held 1 -> 12 outputs; window_valid only at (2,2) and (3,2); eol at col 3; eof at (3,2); frame_done 2 cycles after the eof acceptance.
REQ-037 W=4, H=3, out_ready low for 5 cycles mid-line -> in_ready=0, outputs frozen, no pixel lost or duplicated; sequence resumes in order.
REQ-038 start with W=2, H=5 -> cfg_err pulses 1 cycle, state stays IDLE, in_ready=0.
REQ-039 start pulse at row 1 of a 5x5 frame -> ignored; frame completes with 25 outputs.
REQ-040 rst at pixel (1,1) of a 4x4 frame -> next cycle out_valid=0 and in_ready=0; a new start restarts at (0,0) with no frame_done from the aborted frame.
REQ-041 Single-pixel consume plus accept every cycle, W=3, H=3 -> out_valid continuously high for 9 cycles, window_valid only at (2,2).
